// File: rtl/sequencia_envio_medida_pkg.sv
// Shared definitions for the measurement sequencer: FSM state encoding and
// the digit-index width helper.
package sequencia_envio_medida_pkg;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    CONVERTE  = 4'd1,
    CARREGA   = 4'd2,
    TRANSMITE = 4'd3,
    ESPERA    = 4'd4,
    FINAL     = 4'd5
  } estado_t;

  localparam int N_DIGITOS_PADRAO = 4;
  localparam int INDICE_W         = $clog2(N_DIGITOS_PADRAO);

  // Width of the digit index k; never narrower than one bit so k[0] exists.
  function automatic int largura_indice(input int n_digitos);
    return (n_digitos > 1) ? $clog2(n_digitos) : 1;
  endfunction

endpackage

// File: rtl/sequencia_envio_medida_conversor.sv
// Iterative double-dabble: one add-3/shift iteration per 'passo' cycle.
// 'carrega' latches the binary value and clears the BCD accumulator;
// 'fim' is high during the last iteration, so the result is final right
// after the edge on which 'fim' and 'passo' are both high.
module conversor_bin_bcd_seq #(
  parameter int N_BITS    = 12,
  parameter int N_DIGITOS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   carrega,
  input  logic                   passo,
  input  logic [N_BITS-1:0]      valor,
  output logic [4*N_DIGITOS-1:0] bcd,
  output logic                   fim
);

  localparam int CW = $clog2(N_BITS + 1);

  logic [N_BITS-1:0]      bin_q;
  logic [4*N_DIGITOS-1:0] bcd_q;
  logic [4*N_DIGITOS-1:0] bcd_aj;
  logic [CW-1:0]          cont_q;

  // Add 3 to every nibble >= 5 ahead of the shift.
  always_comb begin
    bcd_aj = bcd_q;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_aj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Iteration counter: the only control state in the converter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else if (carrega) begin
      cont_q <= CW'(N_BITS);
    end else if (passo && (cont_q != '0)) begin
      cont_q <= cont_q - CW'(1);
    end
  end

  // Shift register {BCD, binary}; always loaded before use, so no reset.
  always_ff @(posedge clock) begin
    if (carrega) begin
      bin_q <= valor;
      bcd_q <= '0;
    end else if (passo && (cont_q != '0)) begin
      {bcd_q, bin_q} <= {bcd_aj, bin_q} << 1;
    end
  end

  assign bcd = bcd_q;
  assign fim = (cont_q == CW'(1));

endmodule

// File: rtl/sequencia_envio_medida.sv
// Measurement sequencer: converts a binary value to BCD and hands the digits,
// most significant first, to the serial BCD transmit datapath one at a time.
module sequencia_envio_medida
  import sequencia_envio_medida_pkg::*;
#(
  parameter int N_BITS    = 12,
  parameter int N_DIGITOS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] valor_binario,
  input  logic              pronto_transmissao_bcd,
  output logic [7:0]        bcd,
  output logic              seletor_valor,
  output logic              inicio_transmissao_bcd,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int K_W   = largura_indice(N_DIGITOS);
  localparam int BCD_W = 4 * N_DIGITOS;

  estado_t          estado, estado_prox;
  logic [K_W-1:0]   k, k_prox;
  logic [BCD_W-1:0] bcd_conv;
  logic             fim_conv;
  logic             carrega_conv;
  logic             passo_conv;

  logic [7:0]       bcd_prox;
  logic             seletor_prox;
  logic             inicio_prox;
  logic             ocupado_prox;
  logic             pronto_prox;

  // Byte holding digit idx: digits 2p+1 and 2p share byte p.
  function automatic logic [7:0] byte_digito(input logic [BCD_W-1:0] v,
                                             input logic [K_W-1:0]   idx);
    int par;
    par = int'(idx) / 2;
    return v[8*par +: 8];
  endfunction

  assign carrega_conv = (estado == INICIAL) && partida;
  assign passo_conv   = (estado == CONVERTE);

  conversor_bin_bcd_seq #(
    .N_BITS    (N_BITS),
    .N_DIGITOS (N_DIGITOS)
  ) u_conversor (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega_conv),
    .passo   (passo_conv),
    .valor   (valor_binario),
    .bcd     (bcd_conv),
    .fim     (fim_conv)
  );

  // State, digit index and all outputs are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado                 <= INICIAL;
      k                      <= '0;
      bcd                    <= '0;
      seletor_valor          <= 1'b0;
      inicio_transmissao_bcd <= 1'b0;
      ocupado                <= 1'b0;
      pronto                 <= 1'b0;
    end else begin
      estado                 <= estado_prox;
      k                      <= k_prox;
      bcd                    <= bcd_prox;
      seletor_valor          <= seletor_prox;
      inicio_transmissao_bcd <= inicio_prox;
      ocupado                <= ocupado_prox;
      pronto                 <= pronto_prox;
    end
  end

  // Next-state and digit-index logic.
  always_comb begin
    estado_prox = estado;
    k_prox      = k;
    case (estado)
      INICIAL: begin
        if (partida) estado_prox = CONVERTE;
      end
      CONVERTE: begin
        if (fim_conv) estado_prox = CARREGA;
      end
      CARREGA: begin
        k_prox      = K_W'(N_DIGITOS - 1);
        estado_prox = TRANSMITE;
      end
      TRANSMITE: begin
        estado_prox = ESPERA;
      end
      ESPERA: begin
        if (pronto_transmissao_bcd) begin
          if (k == '0) begin
            estado_prox = FINAL;
          end else begin
            k_prox      = k - K_W'(1);
            estado_prox = TRANSMITE;
          end
        end
      end
      FINAL: begin
        estado_prox = INICIAL;
      end
      default: begin
        estado_prox = INICIAL;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    bcd_prox     = bcd;
    seletor_prox = seletor_valor;
    if (estado_prox == TRANSMITE) begin
      bcd_prox     = byte_digito(bcd_conv, k_prox);
      seletor_prox = k_prox[0];
    end
    inicio_prox  = (estado_prox == TRANSMITE);
    ocupado_prox = (estado_prox == CONVERTE) || (estado_prox == CARREGA) ||
                   (estado_prox == TRANSMITE) || (estado_prox == ESPERA);
    pronto_prox  = (estado_prox == FINAL);
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_sequencia_envio_medida.sv
// Bench for sequencia_envio_medida: stimulus pushes expected digits/text into
// queues, a monitor pops and compares on every start pulse and every 'pronto'.
module tb_sequencia_envio_medida;

  localparam int N_BITS    = 12;
  localparam int N_DIGITOS = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              partida;
  logic [N_BITS-1:0] valor_binario;
  logic              pronto_transmissao_bcd;
  logic [7:0]        bcd;
  logic              seletor_valor;
  logic              inicio_transmissao_bcd;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  sequencia_envio_medida #(
    .N_BITS    (N_BITS),
    .N_DIGITOS (N_DIGITOS)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .partida                (partida),
    .valor_binario          (valor_binario),
    .pronto_transmissao_bcd (pronto_transmissao_bcd),
    .bcd                    (bcd),
    .seletor_valor          (seletor_valor),
    .inicio_transmissao_bcd (inicio_transmissao_bcd),
    .ocupado                (ocupado),
    .pronto                 (pronto),
    .db_estado              (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       s;
    int         idx;
    int         t;
  } dig_t;

  dig_t        exp_q[$];
  logic [31:0] txt_q[$];

  int          n_checks = 0;
  int          n_erros  = 0;
  int          ciclo    = 0;
  int          u_ult    = 0;
  logic        esp      = 1'b0;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic confere(input string nome, input logic [31:0] atual,
                         input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_erros++;
      $display("FAIL %s: obtido=%0h esperado=%0h ciclo=%0d", nome, atual, esperado, ciclo);
    end
  endtask

  // Reference: decimal digits of v, MS first, grouped two per byte.
  task automatic empilha(input int v, input int t_acc);
    int          d[N_DIGITOS];
    int          pot;
    dig_t        e;
    logic [31:0] txt;
    pot = 1;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      d[i] = (v / pot) % 10;
      pot  = pot * 10;
    end
    txt = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      e.b   = {4'(d[i & ~1]), 4'(d[i | 1])};
      e.s   = ((i % 2) == 0);
      e.idx = i;
      e.t   = t_acc;
      exp_q.push_back(e);
      txt = {txt[23:0], 4'h3, 4'(d[i])};
    end
    txt_q.push_back(txt);
  endtask

  // Transmit datapath model: answers each start 5 cycles later; optionally
  // injects pulses that the sequencer must ignore.
  initial begin : modelo_tx
    int cd;
    cd = 0;
    pronto_transmissao_bcd = 1'b0;
    forever begin
      @(negedge clock);
      pronto_transmissao_bcd = 1'b0;
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            pronto_transmissao_bcd = 1'b1;
            u_ult = ciclo + 1;
          end
        end
        if (inicio_transmissao_bcd) begin
          cd = 4;
          if (esp) pronto_transmissao_bcd = 1'b1;
        end else if (esp && (db_estado == 4'd1)) begin
          pronto_transmissao_bcd = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every presented digit and every end-of-measurement.
  initial begin : monitor
    dig_t        e;
    logic [31:0] texto;
    logic [3:0]  nib;
    int          ndig;
    texto = '0;
    ndig  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        texto = '0;
        ndig  = 0;
      end else begin
        if (inicio_transmissao_bcd) begin
          confere("fila_digito", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            confere("bcd", bcd, e.b);
            confere("seletor", seletor_valor, e.s);
            confere("ocupado_tx", ocupado, 1'b1);
            if (e.idx == 0) confere("latencia_1o", ciclo, e.t + N_BITS + 1);
            else            confere("latencia_dig", ciclo, u_ult);
          end
          nib   = seletor_valor ? bcd[7:4] : bcd[3:0];
          texto = {texto[23:0], 4'h3, nib};
          ndig++;
        end
        if (pronto) begin
          confere("digitos", ndig, N_DIGITOS);
          confere("pronto_lat", ciclo, u_ult);
          confere("ocupado_fim", ocupado, 1'b0);
          confere("fila_texto", txt_q.size() > 0, 1'b1);
          if (txt_q.size() > 0) confere("texto", texto, txt_q.pop_front());
          texto = '0;
          ndig  = 0;
        end
      end
    end
  end

  task automatic inicia(input int v, input bit manter);
    int n;
    n = 0;
    @(negedge clock);
    while ((db_estado != 4'd0) && (n < 400)) begin
      @(negedge clock);
      n++;
    end
    confere("inicial_disp", db_estado, 4'd0);
    valor_binario = N_BITS'(v);
    partida       = 1'b1;
    empilha(v, ciclo + 1);
    if (!manter) begin
      @(negedge clock);
      partida = 1'b0;
    end
  endtask

  task automatic aguarda_pronto();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!pronto && (n < 400));
    confere("pronto_visto", pronto, 1'b1);
  endtask

  task automatic conta_inicios(input int ciclos, output int n);
    n = 0;
    for (int i = 0; i < ciclos; i++) begin
      @(negedge clock);
      if (inicio_transmissao_bcd) n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: obtido=timeout esperado=fim ciclo=%0d", ciclo);
    $fatal(1, "watchdog");
  end

  initial begin : estimulo
    int n, lim, v;
    reset         = 1'b1;
    partida       = 1'b0;
    valor_binario = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    confere("rst_bcd", bcd, 8'h00);
    confere("rst_seletor", seletor_valor, 1'b0);
    confere("rst_inicio", inicio_transmissao_bcd, 1'b0);
    confere("rst_ocupado", ocupado, 1'b0);
    confere("rst_pronto", pronto, 1'b0);
    confere("rst_estado", db_estado, 4'd0);
    conta_inicios(20, n);
    confere("ocioso_sem_inicio", n, 0);

    // Nominal value and boundaries
    inicia(1234, 1'b0);
    aguarda_pronto();
    inicia(0, 1'b0);
    aguarda_pronto();
    inicia(4095, 1'b0);
    aguarda_pronto();

    // Pulses from the transmit path in CONVERTE / coincident with start
    esp = 1'b1;
    inicia(int'($urandom_range(0, 4095)), 1'b0);
    aguarda_pronto();
    esp = 1'b0;

    // partida re-asserted in ESPERA
    inicia(int'($urandom_range(0, 4095)), 1'b0);
    lim = 0;
    while ((db_estado != 4'd4) && (lim < 400)) begin
      @(negedge clock);
      lim++;
    end
    partida       = 1'b1;
    valor_binario = N_BITS'($urandom_range(0, 4095));
    @(negedge clock);
    partida = 1'b0;
    aguarda_pronto();

    // Random values
    for (int j = 0; j < 5; j++) begin
      inicia(int'($urandom_range(0, 4095)), 1'b0);
      aguarda_pronto();
    end

    // Reset in ESPERA after the second digit
    inicia(int'($urandom_range(0, 4095)), 1'b0);
    n   = 0;
    lim = 0;
    while ((n < 2) && (lim < 400)) begin
      @(negedge clock);
      lim++;
      if (inicio_transmissao_bcd) n++;
    end
    @(negedge clock);
    confere("espera_antes_reset", db_estado, 4'd4);
    reset = 1'b1;
    exp_q.delete();
    txt_q.delete();
    @(negedge clock);
    confere("rst_meio_estado", db_estado, 4'd0);
    confere("rst_meio_bcd", bcd, 8'h00);
    confere("rst_meio_seletor", seletor_valor, 1'b0);
    confere("rst_meio_inicio", inicio_transmissao_bcd, 1'b0);
    confere("rst_meio_ocupado", ocupado, 1'b0);
    confere("rst_meio_pronto", pronto, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    conta_inicios(20, n);
    confere("pos_reset_sem_inicio", n, 0);
    inicia(7, 1'b0);
    aguarda_pronto();

    // Back-to-back with partida held high
    inicia(int'($urandom_range(0, 4095)), 1'b1);
    for (int j = 0; j < 3; j++) begin
      aguarda_pronto();
      v             = int'($urandom_range(0, 4095));
      valor_binario = N_BITS'(v);
      empilha(v, ciclo + 2);
    end
    aguarda_pronto();
    partida = 1'b0;

    conta_inicios(30, n);
    confere("final_sem_inicio", n, 0);
    confere("fila_digitos_final", exp_q.size(), 0);
    confere("fila_texto_final", txt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
    $finish;
  end

endmodule

// File: doc/sequencia_envio_medida.md
# sequencia_envio_medida

Upstream sequencer for the serial BCD transmit path. Accepts an unsigned binary measurement and converts it to packed BCD with an iterative double-dabble. It then drives the BCD transmit datapath one ASCII digit at a time, most significant digit first. It owns the `bcd` / `seletor_valor` / `inicio_transmissao_bcd` inputs of that datapath and consumes its `pronto_transmissao_bcd`.

## Interface
Parameters:
- `N_BITS`, 12: width of the binary input value.
- `N_DIGITOS`, 4: BCD digits sent per measurement.
  - Must be even: two digits per `bcd` byte.
  - Must satisfy 10^N_DIGITOS > 2^N_BITS − 1.

Ports:
- `clock`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high.
- `partida`  in  1  start request. Sampled only in `INICIAL`.
- `valor_binario`  in  N_BITS  measurement. Latched in the cycle `partida` is accepted.
- `pronto_transmissao_bcd`  in  1  one-cycle pulse from the transmit datapath when a character has finished.
- `bcd`  out  8  packed BCD byte holding the current digit.
- `seletor_valor`  out  1  1 selects `bcd[7:4]`, 0 selects `bcd[3:0]`.
- `inicio_transmissao_bcd`  out  1  one-cycle start pulse to the transmit datapath.
- `ocupado`  out  1  high while a measurement is being converted or sent.
- `pronto`  out  1  one-cycle pulse after the last digit has been transmitted.
- `db_estado`  out  4  current state encoding, for debug displays.

## Operation
- All outputs are registered. Reset value of every output is 0; `db_estado` = `INICIAL` (0).
- **States:** `INICIAL` → `CONVERTE` → `CARREGA` → `TRANSMITE` → `ESPERA` → (`TRANSMITE` | `FINAL`) → `INICIAL`.
- **`INICIAL`**
  - On `partida` = 1: latch `valor_binario`, clear the BCD shift register, load the bit counter with N_BITS, go to `CONVERTE`.
  - Otherwise stay.
- **`CONVERTE`** (one iteration per cycle)
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {BCD, binary} left by 1; decrement the bit counter.
  - After N_BITS iterations go to `CARREGA`.
- **`CARREGA`**: set digit index k = N_DIGITOS−1.
- **Digit mapping (`CARREGA` and every return to `TRANSMITE`)**
  - `bcd` = BCD byte k/2, i.e. bits [8·(k/2)+7 : 8·(k/2)].
  - `seletor_valor` = k[0].
- **`TRANSMITE`**: `inicio_transmissao_bcd` = 1 for exactly this cycle, then go to `ESPERA`.
- **`ESPERA`**: hold `bcd` and `seletor_valor` stable until `pronto_transmissao_bcd` = 1. Then:
  - if k = 0, go to `FINAL`;
  - otherwise k ← k−1, update `bcd` / `seletor_valor`, go to `TRANSMITE`.
- **`FINAL`**: `pronto` = 1 for one cycle, then return to `INICIAL`.
- **`ocupado`**: 1 in `CONVERTE`, `CARREGA`, `TRANSMITE` and `ESPERA`; 0 in `INICIAL` and `FINAL`.
- **Ignored inputs**
  - `partida` outside `INICIAL`, including in `FINAL`.
  - `pronto_transmissao_bcd` outside `ESPERA`, including a pulse coincident with `inicio_transmissao_bcd`.
- **Reset mid-operation**: return to `INICIAL` next edge, all outputs 0, no further start pulses. The transmit datapath is reset by the same `reset`.

## Timing
- `partida` sampled at edge t:
  - `CONVERTE` spans t+1 … t+N_BITS.
  - `CARREGA` at t+N_BITS+1.
  - First `inicio_transmissao_bcd` high at t+N_BITS+2 (t+14 for N_BITS = 12).
- `pronto_transmissao_bcd` sampled high in `ESPERA` at edge u:
  - next digit's `bcd` / `seletor_valor` are valid at u+1, together with `inicio_transmissao_bcd`;
  - after the last digit, `pronto` is high at u+1 and `ocupado` is low at u+1.
- Earliest next accepted `partida`: u+2.

## Structure
- **Shared package** `sequencia_envio_medida_pkg`:
  - state encoding: `INICIAL`=0, `CONVERTE`=1, `CARREGA`=2, `TRANSMITE`=3, `ESPERA`=4, `FINAL`=5;
  - digit-index width constant, clog2(N_DIGITOS).
- **Sub-module** `conversor_bin_bcd_seq`:
  - iterative double-dabble with `carrega` / `passo` controls and a `fim` flag;
  - separates the converter datapath from the sequencer FSM.

## Test plan
1. **Reset:** assert `reset` 2 cycles, then release → all outputs 0, `db_estado` = 0; `partida` = 0 for 20 cycles → no `inicio_transmissao_bcd`.
2. **Value 1234, `pronto_transmissao_bcd` pulsed 5 cycles after each start:**
   - four start pulses with (`bcd`, `seletor_valor`) = (8'h12,1), (8'h12,0), (8'h34,1), (8'h34,0);
   - model of the transmit datapath receives ASCII "1234";
   - `pronto` asserts once.
3. **Boundary values:** 0 → digits 0,0,0,0; 4095 → digits 4,0,9,5; first start exactly 14 cycles after `partida`.
4. **Ignored inputs:**
   - `partida` re-asserted during `ESPERA` → ignored, sequence unchanged;
   - `pronto_transmissao_bcd` pulsed in `CONVERTE` or `TRANSMITE` → ignored, no digit skipped.
5. **Reset mid-transfer:** `reset` asserted in `ESPERA` after the 2nd digit → `INICIAL` next edge, outputs 0, no further starts; new `partida` with value 7 → digits 0,0,0,7.
6. **Back-to-back measurements:** `partida` held high continuously → next measurement starts exactly 2 cycles after the previous last `pronto_transmissao_bcd`, with the newly latched value.
